// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- UART receiver with oversampling tick, valid/ready output register,
// framing-error and overrun pulses.
//
// Optional feature (compile-time macro UART_RX_PARITY_EN):
//   adds a parity bit between the data bits and the stop bit, the PARITY_ODD
//   parameter (0 = even, 1 = odd) and the parity_err output.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   tick       in   1-cycle strobe at OVERSAMPLE x baud; all bit timing counts it
//   rxd        in   asynchronous serial line, idle high
//   data       out  received byte, stable while valid is high
//   valid      out  data holds an unconsumed byte
//   ready      in   consumer accepts data when valid && ready
//   frame_err  out  1-cycle pulse: stop bit sampled low
//   overrun    out  1-cycle pulse: byte completed while the previous one was
//                   still held and not consumed; the new byte is dropped
//   parity_err out  (UART_RX_PARITY_EN only) parity of the delivered byte is
//                   wrong; registered together with data/valid
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
  , parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
`ifdef UART_RX_PARITY_EN
  , output logic               parity_err
`endif
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_BITS + 1);

  localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_END  = BC_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Synchronizer: rx_s_q is the synchronized line, rx_d_q its delayed copy.
  logic sync1_q, rx_s_q, rx_d_q;

  state_t                 state_q, state_d;
  logic [SC_W-1:0]        sc_q, sc_d;
  logic [BC_W-1:0]        bc_q, bc_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   done_q, done_d;
  logic                   frame_err_q, frame_err_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   parity_err_q, parity_err_d;
`endif

  // ---------------------------------------------------------------------------
  // Receive FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    sc_d        = sc_q;
    bc_d        = bc_q;
    shift_d     = shift_q;
    done_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bit_d   = par_bit_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Falling edge on the synchronized line; no tick needed.
        if (rx_d_q && !rx_s_q) begin
          state_d = S_START;
          sc_d    = '0;
        end
      end

      S_START: begin
        if (tick) begin
          if (sc_q == SC_HALF) begin
            if (rx_s_q) begin
              state_d = S_IDLE;          // glitch, not a start bit
            end else begin
              state_d = S_DATA;
              sc_d    = '0;
              bc_d    = '0;
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (sc_q == SC_LAST) begin
            // Shifting in at the MSB end leaves bit 0 holding the first
            // (LSB) sample once all DATA_BITS have arrived.
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            sc_d    = '0;
            bc_d    = bc_q + 1'b1;
            if (bc_q == BC_END) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (sc_q == SC_LAST) begin
            par_bit_d = rx_s_q;
            sc_d      = '0;
            state_d   = S_STOP;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          if (sc_q == SC_LAST) begin
            // Back to IDLE at mid stop bit so a back-to-back start edge is
            // caught without loss.
            state_d = S_IDLE;
            sc_d    = '0;
            if (rx_s_q) done_d      = 1'b1;
            else        frame_err_d = 1'b1;
          end else begin
            sc_d = sc_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register: evaluated on the cycle after the completing sample
  // ---------------------------------------------------------------------------
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif

    if (done_q) begin
      if (!valid_q || ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err_d = (^{shift_q, par_bit_q}) ^ PARITY_ODD;
`endif
      end else begin
        overrun_d = 1'b1;              // new byte dropped, data untouched
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge value of every other flop.
    if (rst) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_d_q      <= 1'b1;
      state_q     <= S_IDLE;
      sc_q        <= '0;
      bc_q        <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= rxd;
      rx_s_q      <= sync1_q;
      rx_d_q      <= rx_s_q;
      state_q     <= state_d;
      sc_q        <= sc_d;
      bc_q        <= bc_d;
      shift_q     <= shift_d;
      done_q      <= done_d;
      frame_err_q <= frame_err_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
// tick every 4 clk, OVERSAMPLE = 16, so one bit lasts 64 clk.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int OS      = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK = OS * TICK_DIV;
`ifdef UART_RX_PARITY_EN
  localparam int N_TICKS = OS / 2 + OS * 10;   // start half + 8 data + parity + stop
`else
  localparam int N_TICKS = OS / 2 + OS * 9;    // start half + 8 data + stop
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rxd       (rxd),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
    , .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Tick is high during every posedge whose index is a multiple of 4.
  initial forever begin
    @(negedge clk);
    tick = ((cyc + 1) % TICK_DIV == 0);
  end

  // ---------------------------------------------------------------------------
  // Monitor: monotonic counters, read as deltas by the test sequence
  // ---------------------------------------------------------------------------
  typedef struct {
    int hs;         // handshakes (valid && ready)
    int vcyc;       // cycles with valid high
    int ferr;       // frame_err cycles
    int ferr_long;  // frame_err high on two consecutive cycles
    int ovr;        // overrun cycles
    int ovr_long;
    int perr;       // handshakes carrying parity_err
    int rise;       // cycle index of the most recent valid rise
  } stats_t;

  stats_t     mon = '{default: 0};
  logic [7:0] hs_q[$];
  logic       prev_valid = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;

  initial forever begin
    @(negedge clk);
    #1;
    if (valid && !prev_valid) mon.rise = cyc;
    if (valid) mon.vcyc++;
    if (valid && ready) begin
      mon.hs++;
      hs_q.push_back(data);
`ifdef UART_RX_PARITY_EN
      if (parity_err) mon.perr++;
`endif
    end
    if (frame_err) begin
      mon.ferr++;
      if (prev_ferr) mon.ferr_long++;
    end
    if (overrun) begin
      mon.ovr++;
      if (prev_ovr) mon.ovr_long++;
    end
    prev_valid = valid;
    prev_ferr  = frame_err;
    prev_ovr   = overrun;
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Line driver (all calls start and end on a negedge)
  // ---------------------------------------------------------------------------
  task automatic send_bit(input logic b);
    rxd = b;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame_p(input logic [7:0] d, input logic stop, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par !== (^d)) $display("note: parity bit ignored without parity build");
`endif
    send_bit(stop);
  endtask

  // Frame with correct even parity (only emitted in the parity build).
  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_frame_p(d, stop, ^d);
  endtask

  task automatic idle(input int bits);
    rxd = 1'b1;
    repeat (bits * BIT_CLK) @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors (ready held 1)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_hs;
    int         exp_ferr;
  } vec_t;

  vec_t   vecs[6];
  stats_t base;

  initial begin
    vecs[0] = '{d: 8'h00, stop: 1'b1, exp_hs: 1, exp_ferr: 0};
    vecs[1] = '{d: 8'hFF, stop: 1'b1, exp_hs: 1, exp_ferr: 0};
    vecs[2] = '{d: 8'h80, stop: 1'b1, exp_hs: 1, exp_ferr: 0};
    vecs[3] = '{d: 8'h01, stop: 1'b1, exp_hs: 1, exp_ferr: 0};
    vecs[4] = '{d: 8'h5A, stop: 1'b0, exp_hs: 0, exp_ferr: 1};
    vecs[5] = '{d: 8'hC3, stop: 1'b1, exp_hs: 1, exp_ferr: 0};

    // ---- reset state ----
    repeat (4) @(negedge clk);
    check("reset data", data, 0);
    check("reset valid", valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    rst = 1'b0;
    idle(2);

    // ---- scenario 1: 0x55, exact latency, single-cycle valid ----
    begin
      int c0, first, exp_rise;
      ready = 1'b1;
      base  = mon;
      c0    = cyc;
      first = ((c0 + 3) / TICK_DIV + 1) * TICK_DIV;
      exp_rise = first + (N_TICKS - 1) * TICK_DIV + 1;
      send_frame(8'h55, 1'b1);
      idle(2);
      check("s1 handshakes", mon.hs - base.hs, 1);
      check("s1 valid cycles", mon.vcyc - base.vcyc, 1);
      check("s1 data", hs_q[hs_q.size() - 1], 8'h55);
      check("s1 valid rise cycle", mon.rise, exp_rise);
      check("s1 frame_err", mon.ferr - base.ferr, 0);
      check("s1 overrun", mon.ovr - base.ovr, 0);
    end

    // ---- table of directed frames ----
    for (int i = 0; i < 6; i++) begin
      base = mon;
      send_frame(vecs[i].d, vecs[i].stop);
      idle(2);
      check($sformatf("vec%0d handshakes", i), mon.hs - base.hs, vecs[i].exp_hs);
      check($sformatf("vec%0d valid cycles", i), mon.vcyc - base.vcyc, vecs[i].exp_hs);
      check($sformatf("vec%0d frame_err", i), mon.ferr - base.ferr, vecs[i].exp_ferr);
      check($sformatf("vec%0d overrun", i), mon.ovr - base.ovr, 0);
      if (vecs[i].exp_hs == 1)
        check($sformatf("vec%0d data", i), hs_q[hs_q.size() - 1], vecs[i].d);
    end

    // ---- scenario 2: back-to-back with ready low -> overrun ----
    ready = 1'b0;
    base  = mon;
    send_frame(8'hA3, 1'b1);
    send_frame(8'h3C, 1'b1);
    idle(2);
    check("s2 valid held", valid, 1);
    check("s2 data", data, 8'hA3);
    check("s2 overrun pulses", mon.ovr - base.ovr, 1);
    check("s2 overrun width", mon.ovr_long - base.ovr_long, 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("s2 valid after ready", valid, 0);
    check("s2 data kept", data, 8'hA3);
    repeat (4) @(negedge clk);
    check("s2 handshakes", mon.hs - base.hs, 1);

    // ---- scenario 3: short glitch, then a good frame ----
    ready = 1'b1;
    base  = mon;
    rxd = 1'b0;
    repeat (3 * TICK_DIV) @(negedge clk);
    idle(3);
    check("s3 glitch valid", mon.vcyc - base.vcyc, 0);
    check("s3 glitch frame_err", mon.ferr - base.ferr, 0);
    send_frame(8'h0F, 1'b1);
    idle(2);
    check("s3 handshakes", mon.hs - base.hs, 1);
    check("s3 data", hs_q[hs_q.size() - 1], 8'h0F);

    // ---- scenario 4: framing error, line held low, recovery ----
    base = mon;
    send_frame(8'hFF, 1'b0);
    repeat (2 * BIT_CLK) @(negedge clk);       // rxd still low
    check("s4 frame_err pulses", mon.ferr - base.ferr, 1);
    check("s4 frame_err width", mon.ferr_long - base.ferr_long, 0);
    check("s4 no valid", mon.vcyc - base.vcyc, 0);
    idle(1);
    ready = 1'b0;
    send_frame(8'h81, 1'b1);
    idle(2);
    check("s4 data", data, 8'h81);
    check("s4 valid", valid, 1);
    check("s4 single frame_err", mon.ferr - base.ferr, 1);

    // ---- scenario 5: reset during bit 4 of 0x99 ----
    ready = 1'b1;
    begin
      logic [7:0] b99;
      b99 = 8'h99;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(b99[i]);
      rxd = b99[4];
      repeat (BIT_CLK / 2) @(negedge clk);
    end
    base = mon;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("s5 data after rst", data, 0);
    check("s5 valid after rst", valid, 0);
    check("s5 frame_err after rst", frame_err, 0);
    check("s5 overrun after rst", overrun, 0);
    idle(12);
    check("s5 no byte", mon.vcyc - base.vcyc, 0);
    check("s5 no frame_err", mon.ferr - base.ferr, 0);
    base = mon;
    send_frame(8'h42, 1'b1);
    idle(2);
    check("s5 handshakes", mon.hs - base.hs, 1);
    check("s5 data", hs_q[hs_q.size() - 1], 8'h42);

`ifdef UART_RX_PARITY_EN
    // ---- scenario 6: parity ----
    ready = 1'b0;
    send_frame_p(8'h07, 1'b1, 1'b1);
    idle(2);
    check("s6 good data", data, 8'h07);
    check("s6 good valid", valid, 1);
    check("s6 good parity_err", parity_err, 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    send_frame_p(8'h07, 1'b1, 1'b0);
    idle(2);
    check("s6 bad valid", valid, 1);
    check("s6 bad data", data, 8'h07);
    check("s6 bad parity_err", parity_err, 1);
    ready = 1'b1;
    @(negedge clk);
`endif

    // ---- randomized frames against a byte-list reference model ----
    begin
      logic [7:0] exp_q[$];
      int         exp_ferr;
      int         hs0;
      exp_ferr = 0;
      ready = 1'b1;
      base  = mon;
      hs0   = hs_q.size();
      for (int n = 0; n < 30; n++) begin
        logic [7:0] d;
        logic       stop;
        int         gap;
        d    = 8'($urandom);
        stop = ($urandom_range(0, 3) != 0);
        gap  = $urandom_range(0, 2);
        if (!stop && gap == 0) gap = 1;       // line must rise before next start
        if (stop) exp_q.push_back(d);
        else      exp_ferr++;
        send_frame(d, stop);
        if (gap > 0) idle(gap);
      end
      idle(2);
      check("rand handshakes", mon.hs - base.hs, exp_q.size());
      check("rand frame_err", mon.ferr - base.ferr, exp_ferr);
      check("rand overrun", mon.ovr - base.ovr, 0);
      check("rand parity_err", mon.perr - base.perr, 0);
      for (int k = 0; k < exp_q.size(); k++) begin
        if (hs0 + k < hs_q.size())
          check($sformatf("rand byte %0d", k), hs_q[hs0 + k], exp_q[k]);
        else
          check($sformatf("rand byte %0d missing", k), 32'hFFFF_FFFF, exp_q[k]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
